mc_main_control: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, write strobes and the 2-bit alu_op consumed by alu_control (00 add, 01 sub, 10 funct-decoded). Memory accesses stall on a ready handshake, so the block works with single-cycle and wait-stated memories.

---
 rtl/mc_main_control.sv | 159 +++++++++++++++
 tb/tb_mc_main_control.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// mc_main_control -- main control FSM for the multi-cycle MIPS datapath.
//
// Steps each instruction through fetch / decode / execute / memory /
// writeback and decodes the datapath controls from the current state.
// Memory states hold on mem_ready so wait-stated memories work unchanged.
//
// Ports:
//   clk, rst_n     clock (rising edge), async active-low reset
//   opcode         IR[31:26], meaningful from DECODE onward
//   mem_ready      memory finishes the current access this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
//   pc_source      datapath controls
//   state          current state code (debug)
module mc_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEM_ADDR   = 4'd2,
    S_MEM_READ   = 4'd3,
    S_MEM_WB     = 4'd4,
    S_MEM_WRITE  = 4'd5,
    S_EXECUTE    = 4'd6,
    S_R_COMPLETE = 4'd7,
    S_BRANCH     = 4'd8,
    S_JUMP       = 4'd9,
    S_IDLE       = 4'd15
  } state_e;

  state_e state_q, state_d;

  // Reset lands in IDLE, whose outputs are all 0, so an async reset
  // silences every strobe immediately and no partial writeback escapes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+4 happen only on the completing cycle, giving a
        // single pulse no matter how many wait cycles came first.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        alu_src_b = 2'b11;  // speculative branch target into ALUOut
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)            state_d = S_EXECUTE;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_FETCH;  // NOP
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_COMPLETE;
      end

      S_R_COMPLETE: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end

      default: state_d = S_FETCH;  // codes 10-14: recover, outputs stay 0
    endcase
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Scoreboard bench for mc_main_control. The stimulus process drives
// opcode/mem_ready for each cycle and queues the hand-computed state and
// control word for that cycle; the monitor pops and compares on the
// falling edge.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state)
  );

  always #5 clk = ~clk;

  // Control word layout:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  localparam logic [15:0] C_IDLE  = 16'h0000;
  localparam logic [15:0] C_FRDY  = 16'h9410; // pcw mr irw asb=01
  localparam logic [15:0] C_FWAIT = 16'h1010; // mr asb=01
  localparam logic [15:0] C_DEC   = 16'h0030; // asb=11
  localparam logic [15:0] C_MA    = 16'h0060; // asa asb=10
  localparam logic [15:0] C_MR    = 16'h3000; // iod mr
  localparam logic [15:0] C_WB    = 16'h0280; // m2r rw
  localparam logic [15:0] C_MW    = 16'h2800; // iod mw
  localparam logic [15:0] C_EXE   = 16'h0048; // asa aop=10
  localparam logic [15:0] C_RC    = 16'h0180; // rd rw
  localparam logic [15:0] C_BR    = 16'h4045; // pwc asa aop=01 psrc=01
  localparam logic [15:0] C_J     = 16'h8002; // pcw psrc=10

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BQ = 6'b000100, JJ = 6'b000010, BAD = 6'b111111;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [15:0] ctl;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_step = 0;

  task automatic push(input logic [3:0] st, input logic [15:0] ctl);
    exp_t e;
    e.idx = n_step; e.st = st; e.ctl = ctl;
    sb_q.push_back(e);
    n_step++;
  endtask

  // One cycle: drive inputs just after the edge, queue the expectation.
  task automatic step(input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [15:0] ctl);
    opcode = op; mem_ready = rdy;
    push(st, ctl);
    @(posedge clk); #1;
  endtask

  // Monitor: every falling edge with a pending expectation is a DUT output.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb_q.pop_front();
      act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source};
      n_chk++;
      if (state !== e.st) begin
        n_fail++;
        $display("FAIL state step %0d: got %0d expected %0d", e.idx, state, e.st);
      end
      n_chk++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL ctl step %0d (state %0d): got %h expected %h",
                 e.idx, state, act, e.ctl);
      end
      n_chk++;
      if (mem_read && mem_write) begin
        n_fail++;
        $display("FAIL rd_wr_excl step %0d: mem_read=%b mem_write=%b expected not both 1",
                 e.idx, mem_read, mem_write);
      end
    end
  end

  initial begin
    rst_n = 1'b0; opcode = RT; mem_ready = 1'b1;
    @(posedge clk); #1;
    // Reset held 3 cycles: IDLE, all outputs 0
    step(RT, 1, 4'd15, C_IDLE);
    step(RT, 1, 4'd15, C_IDLE);
    step(RT, 1, 4'd15, C_IDLE);
    rst_n = 1'b1;
    // R-type: 15,0,1,6,7
    step(RT, 1, 4'd15, C_IDLE);
    step(RT, 1, 4'd0,  C_FRDY);
    step(RT, 1, 4'd1,  C_DEC);
    step(RT, 1, 4'd6,  C_EXE);
    step(RT, 1, 4'd7,  C_RC);
    // LW with 2 wait cycles in MEM_READ
    step(LW, 1, 4'd0,  C_FRDY);
    step(LW, 1, 4'd1,  C_DEC);
    step(LW, 1, 4'd2,  C_MA);
    step(LW, 0, 4'd3,  C_MR);
    step(LW, 0, 4'd3,  C_MR);
    step(LW, 1, 4'd3,  C_MR);
    step(LW, 1, 4'd4,  C_WB);
    // SW with 3 fetch wait cycles, single-cycle store
    step(SW, 0, 4'd0,  C_FWAIT);
    step(SW, 0, 4'd0,  C_FWAIT);
    step(SW, 0, 4'd0,  C_FWAIT);
    step(SW, 1, 4'd0,  C_FRDY);
    step(SW, 1, 4'd1,  C_DEC);
    step(SW, 1, 4'd2,  C_MA);
    step(SW, 1, 4'd5,  C_MW);
    // SW with one wait cycle on the store
    step(SW, 1, 4'd0,  C_FRDY);
    step(SW, 1, 4'd1,  C_DEC);
    step(SW, 1, 4'd2,  C_MA);
    step(SW, 0, 4'd5,  C_MW);
    step(SW, 1, 4'd5,  C_MW);
    // BEQ
    step(BQ, 1, 4'd0,  C_FRDY);
    step(BQ, 1, 4'd1,  C_DEC);
    step(BQ, 1, 4'd8,  C_BR);
    // J
    step(JJ, 1, 4'd0,  C_FRDY);
    step(JJ, 1, 4'd1,  C_DEC);
    step(JJ, 1, 4'd9,  C_J);
    // Illegal opcode behaves as NOP
    step(BAD, 1, 4'd0, C_FRDY);
    step(BAD, 1, 4'd1, C_DEC);
    // R-type with mem_ready low outside memory states: must be ignored
    step(RT, 1, 4'd0,  C_FRDY);
    step(RT, 0, 4'd1,  C_DEC);
    step(RT, 0, 4'd6,  C_EXE);
    step(RT, 0, 4'd7,  C_RC);
    // LW stalled in MEM_READ, then async reset mid-cycle
    step(LW, 1, 4'd0,  C_FRDY);
    step(LW, 1, 4'd1,  C_DEC);
    step(LW, 1, 4'd2,  C_MA);
    step(LW, 0, 4'd3,  C_MR);
    opcode = LW; mem_ready = 1'b0;
    #2 rst_n = 1'b0;            // between edges; sampled before next edge
    push(4'd15, C_IDLE);
    @(posedge clk); #1;
    step(LW, 0, 4'd15, C_IDLE);
    rst_n = 1'b1;
    step(RT, 1, 4'd15, C_IDLE);
    step(RT, 1, 4'd0,  C_FRDY);
    step(RT, 1, 4'd1,  C_DEC);
    step(RT, 1, 4'd6,  C_EXE);
    // let the monitor drain the last entry
    @(negedge clk); #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached expected test end");
    $fatal(1, "watchdog");
  end

endmodule
